// File: rtl/rob_id_pkg.sv
// Shared helpers for the ID remap allocator: index widths and unique-ID pack/unpack.
package rob_id_pkg;

    localparam int UID_MAX_W = 64;
    typedef logic [UID_MAX_W-1:0] uid_t;

    function automatic int row_w(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

    function automatic int col_w(input int num_cols);
        return (num_cols > 1) ? $clog2(num_cols) : 1;
    endfunction

    function automatic uid_t uid_pack(input uid_t row, input uid_t col, input int cw);
        return (row << cw) | col;
    endfunction

    function automatic uid_t uid_row(input uid_t uid, input int rw, input int cw);
        return (uid >> cw) & ((uid_t'(1) << rw) - uid_t'(1));
    endfunction

    function automatic uid_t uid_col(input uid_t uid, input int cw);
        return uid & ((uid_t'(1) << cw) - uid_t'(1));
    endfunction

    // Any bit above {row,col} set means the UID can never have been issued.
    function automatic logic uid_upper_nz(input uid_t uid, input int rw, input int cw);
        return |(uid >> (rw + cw));
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request bit is set and where.
module lsb_prio_enc #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/id_remap_allocator_v2.sv
// Binds in-flight original IDs to matrix rows and issues unique {row,col} IDs;
// frees return the original ID one cycle later, with error flagging for bogus UIDs.
module id_remap_allocator_v2
    import rob_id_pkg::*;
#(
    parameter int ID_WIDTH        = 16,
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int MAX_OUTSTANDING = NUM_ROWS * NUM_COLS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alloc_valid,
    input  logic [ID_WIDTH-1:0]                    alloc_orig_id,
    output logic                                   alloc_ready,
    output logic [ID_WIDTH-1:0]                    alloc_uid,
    input  logic                                   free_valid,
    input  logic [ID_WIDTH-1:0]                    free_uid,
    output logic                                   free_rsp_valid,
    output logic [ID_WIDTH-1:0]                    free_rsp_orig_id,
    output logic                                   free_rsp_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt,
    output logic                                   full,
    output logic                                   empty
);

    localparam int ROW_W = row_w(NUM_ROWS);
    localparam int COL_W = col_w(NUM_COLS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic                bound;
        logic [ID_WIDTH-1:0] orig_id;
        logic [NUM_COLS-1:0] bitmap;
    } remap_row_t;

    remap_row_t          rows_q [NUM_ROWS];
    remap_row_t          rows_d [NUM_ROWS];
    logic [ID_WIDTH-1:0] tags_q [NUM_ROWS][NUM_COLS];
    logic [ID_WIDTH-1:0] tags_d [NUM_ROWS][NUM_COLS];
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_ROWS-1:0] hit_vec, unbound_vec;
    logic                hit_any, unbound_any;
    logic [ROW_W-1:0]    hit_idx, unbound_idx, sel_row;
    logic [NUM_COLS-1:0] col_free_vec;
    logic                col_found;
    logic [COL_W-1:0]    col_idx;
    logic                alloc_fire;

    logic [ROW_W-1:0]    free_row;
    logic [COL_W-1:0]    free_col;
    logic                free_err, free_ok;

    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            hit_vec[r]     = rows_q[r].bound && (rows_q[r].orig_id == alloc_orig_id);
            unbound_vec[r] = ~rows_q[r].bound;
        end
    end

    // At most one row can hold a given ID, so the encoder just converts one-hot to index.
    lsb_prio_enc #(.N(NUM_ROWS)) u_hit_enc (.req(hit_vec), .found(hit_any), .idx(hit_idx));
    lsb_prio_enc #(.N(NUM_ROWS)) u_row_enc (.req(unbound_vec), .found(unbound_any), .idx(unbound_idx));

    assign sel_row      = hit_any ? hit_idx : unbound_idx;
    assign col_free_vec = ~rows_q[sel_row].bitmap;

    lsb_prio_enc #(.N(NUM_COLS)) u_col_enc (.req(col_free_vec), .found(col_found), .idx(col_idx));

    // A full hit row stalls rather than spilling, keeping per-ID ordering in one row.
    assign alloc_ready = ~full & (hit_any ? col_found : unbound_any);
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_uid   = ID_WIDTH'(uid_pack(uid_t'(sel_row), uid_t'(col_idx), COL_W));

    assign free_row = ROW_W'(uid_row(uid_t'(free_uid), ROW_W, COL_W));
    assign free_col = COL_W'(uid_col(uid_t'(free_uid), COL_W));
    assign free_err = uid_upper_nz(uid_t'(free_uid), ROW_W, COL_W) | ~rows_q[free_row].bitmap[free_col];
    assign free_ok  = free_valid & ~free_err;

    always_comb begin
        rows_d = rows_q;
        tags_d = tags_q;
        if (free_ok) begin
            rows_d[free_row].bitmap[free_col] = 1'b0;
        end
        if (alloc_fire) begin
            rows_d[sel_row].bound           = 1'b1;
            rows_d[sel_row].orig_id         = alloc_orig_id;
            rows_d[sel_row].bitmap[col_idx] = 1'b1;
            tags_d[sel_row][col_idx]        = alloc_orig_id;
        end
        // Evaluated after the alloc so a same-cycle hit on the emptied row keeps it bound.
        if (free_ok && (rows_d[free_row].bitmap == '0)) begin
            rows_d[free_row].bound = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(alloc_fire) - CNT_W'(free_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                rows_q[r] <= '0;
                for (int c = 0; c < NUM_COLS; c++) begin
                    tags_q[r][c] <= '0;
                end
            end
            cnt_q            <= '0;
            free_rsp_valid   <= 1'b0;
            free_rsp_err     <= 1'b0;
            free_rsp_orig_id <= '0;
        end else begin
            rows_q           <= rows_d;
            tags_q           <= tags_d;
            cnt_q            <= cnt_d;
            free_rsp_valid   <= free_valid;
            free_rsp_err     <= free_valid & free_err;
            free_rsp_orig_id <= free_ok ? tags_q[free_row][free_col] : '0;
        end
    end

    assign outstanding_cnt = cnt_q;
    assign full            = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty           = (cnt_q == '0);

endmodule

// File: tb/tb_id_remap_allocator_v2.sv
// Directed plus randomized bench for id_remap_allocator_v2 against a live-UID table model.
module tb_id_remap_allocator_v2;

    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int IW   = 16;
    localparam int MAXO = NR * NC;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic [IW-1:0] alloc_orig_id;
    logic          alloc_ready;
    logic [IW-1:0] alloc_uid;
    logic          free_valid;
    logic [IW-1:0] free_uid;
    logic          free_rsp_valid;
    logic [IW-1:0] free_rsp_orig_id;
    logic          free_rsp_err;
    logic [CW-1:0] outstanding_cnt;
    logic          full;
    logic          empty;

    id_remap_allocator_v2 #(
        .ID_WIDTH(IW), .NUM_ROWS(NR), .NUM_COLS(NC), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_orig_id(alloc_orig_id),
        .alloc_ready(alloc_ready), .alloc_uid(alloc_uid),
        .free_valid(free_valid), .free_uid(free_uid),
        .free_rsp_valid(free_rsp_valid), .free_rsp_orig_id(free_rsp_orig_id),
        .free_rsp_err(free_rsp_err),
        .outstanding_cnt(outstanding_cnt), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: which UIDs are live and which original ID each carries.
    bit            m_live [MAXO];
    logic [IW-1:0] m_id   [MAXO];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int u = 0; u < MAXO; u++) n += m_live[u] ? 1 : 0;
        return n;
    endfunction

    task automatic m_clear();
        for (int u = 0; u < MAXO; u++) begin
            m_live[u] = 1'b0;
            m_id[u]   = '0;
        end
    endtask

    // Row owning the ID is any row with a live UID of that ID; otherwise lowest row with nothing live.
    task automatic m_alloc(input logic [IW-1:0] id, output bit rdy, output int uid);
        int  hr;
        bit  row_used;
        rdy = 1'b0;
        uid = 0;
        hr  = -1;
        if (m_count() >= MAXO) return;
        for (int u = 0; u < MAXO; u++)
            if (m_live[u] && m_id[u] == id) hr = u / NC;
        if (hr >= 0) begin
            for (int c = NC - 1; c >= 0; c--)
                if (!m_live[hr * NC + c]) begin
                    rdy = 1'b1;
                    uid = hr * NC + c;
                end
        end else begin
            for (int r = NR - 1; r >= 0; r--) begin
                row_used = 1'b0;
                for (int c = 0; c < NC; c++) row_used |= m_live[r * NC + c];
                if (!row_used) begin
                    rdy = 1'b1;
                    uid = r * NC;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_orig_id = '0;
        free_valid  = 1'b0; free_uid      = '0;
        #1;
        m_clear();
        check("rst_cnt", 32'(outstanding_cnt), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_rsp_valid", 32'(free_rsp_valid), 0);
        check("rst_rsp_err", 32'(free_rsp_err), 0);
        check("rst_ready", 32'(alloc_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_cycle(input bit av, input logic [IW-1:0] aid, input bit fv, input logic [IW-1:0] fu);
        bit            rdy;
        int            uid;
        bit            ferr;
        logic [IW-1:0] forig;
        alloc_valid = av; alloc_orig_id = aid;
        free_valid  = fv; free_uid      = fu;
        #2;
        m_alloc(aid, rdy, uid);
        check("cnt", 32'(outstanding_cnt), m_count());
        check("full", 32'(full), (m_count() == MAXO) ? 1 : 0);
        check("empty", 32'(empty), (m_count() == 0) ? 1 : 0);
        check("alloc_ready", 32'(alloc_ready), 32'(rdy));
        if (av && rdy) check("alloc_uid", 32'(alloc_uid), uid);
        if (fu >= MAXO) ferr = 1'b1;
        else            ferr = !m_live[fu];
        forig = ferr ? '0 : m_id[fu];
        if (fv && !ferr) m_live[fu] = 1'b0;
        if (av && rdy) begin
            m_live[uid] = 1'b1;
            m_id[uid]   = aid;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(free_rsp_valid), 32'(fv));
        check("rsp_err", 32'(free_rsp_err), 32'(fv && ferr));
        check("rsp_orig", 32'(free_rsp_orig_id), fv ? 32'(forig) : 0);
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
    endtask

    initial begin
        int            live_q [$];
        bit            av, fv;
        logic [IW-1:0] aid, fu;

        do_reset();
        do_cycle(1, 16'h005A, 0, 0);
        do_cycle(1, 16'h005A, 0, 0);
        do_cycle(0, 0, 0, 0);

        do_reset();
        repeat (4) do_cycle(1, 16'h0011, 0, 0);
        do_cycle(1, 16'h0011, 0, 0);
        do_cycle(1, 16'h0022, 0, 0);

        do_reset();
        repeat (3) do_cycle(1, 16'h0011, 0, 0);
        do_cycle(0, 0, 1, 16'h0001);
        do_cycle(1, 16'h0011, 0, 0);
        do_cycle(0, 0, 1, 16'h0007);
        do_cycle(0, 0, 1, 16'h0100);
        do_cycle(0, 0, 0, 0);

        do_reset();
        do_cycle(1, 16'h0033, 0, 0);
        do_cycle(1, 16'h0033, 1, 16'h0000);
        do_cycle(1, 16'h0044, 0, 0);
        do_cycle(1, 16'h0033, 0, 0);
        do_cycle(0, 0, 1, 16'h0001);
        do_cycle(0, 0, 1, 16'h0000);
        do_cycle(1, 16'h0055, 0, 0);

        do_reset();
        for (int i = 0; i < MAXO; i++) do_cycle(1, IW'(16'h0060 + i / NC), 0, 0);
        do_cycle(1, 16'h0077, 0, 0);
        do_cycle(1, 16'h0060, 1, 16'h0005);
        do_cycle(0, 0, 1, 16'h0000);
        do_reset();
        do_cycle(1, 16'h005A, 0, 0);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            live_q.delete();
            for (int u = 0; u < MAXO; u++) if (m_live[u]) live_q.push_back(u);
            av  = ($urandom_range(0, 9) < 6);
            aid = IW'($urandom_range(1, 6));
            fv  = ($urandom_range(0, 9) < 5);
            if (live_q.size() > 0 && $urandom_range(0, 9) < 7)
                fu = IW'(live_q[$urandom_range(0, live_q.size() - 1)]);
            else if ($urandom_range(0, 3) == 0)
                fu = IW'($urandom_range(0, 3) << 8) | IW'($urandom_range(0, MAXO - 1));
            else
                fu = IW'($urandom_range(0, MAXO - 1));
            do_cycle(av, aid, fv, fu);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
